// File: rtl/mips_mc_control_if.sv
// Control bundle between the multi-cycle control unit and its datapath/memory.
// The control unit is the master: it reads the IR fields, ALU zero flag and
// memory ready, and drives every enable/select plus the debug state.
interface mips_mc_control_if;
    logic [5:0] op_code;
    logic [5:0] funct;
    logic       zero_flag;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_instr;
    logic       fault;
    logic [1:0] fault_code;
    logic [3:0] state;

    modport master (
        input  op_code, funct, zero_flag, mem_ready,
        output mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
               alu_control, reg_write, reg_dst, mem_to_reg, illegal_instr, fault,
               fault_code, state
    );

    modport slave (
        output op_code, funct, zero_flag, mem_ready,
        input  mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
               alu_control, reg_write, reg_dst, mem_to_reg, illegal_instr, fault,
               fault_code, state
    );
endinterface

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control unit. Moore FSM that walks one instruction through
// 3-5 states over a single shared memory using a req/ready handshake, with a
// bounded memory wait and illegal-instruction trapping.
module mips_mc_control #(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned TIMEOUT_W    = 5,
    parameter bit          TRAP_ILLEGAL = 1'b1,
    parameter bit          ENABLE_BNE   = 1'b1
) (
    input  logic              clk,
    input  logic              arst_n,
    mips_mc_control_if.master bus
);

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAdr   = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StExecute  = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StAddiExec = 4'd10,
        StAddiWb   = 4'd11,
        StJump     = 4'd12,
        StFault    = 4'd13
    } state_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    localparam logic [1:0] FaultNone    = 2'b00;
    localparam logic [1:0] FaultTimeout = 2'b01;
    localparam logic [1:0] FaultIllegal = 2'b10;

    localparam bit                   TimeoutEn = (MEM_TIMEOUT != 0);
    // Only meaningful when TimeoutEn; the wrap for MEM_TIMEOUT == 0 is never compared.
    localparam logic [TIMEOUT_W-1:0] WaitLast  = TIMEOUT_W'(MEM_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]           fault_code_q, fault_code_d;
    logic                 illegal;
    logic                 mem_wait;
    logic                 funct_ok;
    logic [2:0]           funct_alu;

    // R-type function field decode, shared by next-state and output logic.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = AluAdd;
        case (bus.funct)
            6'b100000: funct_alu = AluAdd;
            6'b100010: funct_alu = AluSub;
            6'b100100: funct_alu = AluAnd;
            6'b100101: funct_alu = AluOr;
            6'b101010: funct_alu = AluSlt;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // State, wait counter and fault code registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= StIdle;
            wait_cnt_q   <= '0;
            fault_code_q <= FaultNone;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Next state, memory wait timeout and illegal-instruction handling.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        fault_code_d = fault_code_q;
        illegal      = 1'b0;
        mem_wait     = 1'b0;

        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (bus.mem_ready) state_d = StDecode;
                else               mem_wait = 1'b1;
            end
            StDecode: begin
                case (bus.op_code)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRType:    state_d = StExecute;
                    OpBeq:      state_d = StBranch;
                    OpBne: begin
                        if (ENABLE_BNE) state_d = StBranch;
                        else            illegal = 1'b1;
                    end
                    OpAddi:     state_d = StAddiExec;
                    OpJ:        state_d = StJump;
                    default:    illegal = 1'b1;
                endcase
            end
            StMemAdr: state_d = (bus.op_code == OpSw) ? StMemWrite : StMemRead;
            StMemRead: begin
                if (bus.mem_ready) state_d = StMemWb;
                else               mem_wait = 1'b1;
            end
            StMemWb: state_d = StFetch;
            StMemWrite: begin
                if (bus.mem_ready) state_d = StFetch;
                else               mem_wait = 1'b1;
            end
            StExecute: begin
                if (funct_ok) state_d = StAluWb;
                else          illegal = 1'b1;
            end
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StAddiExec: state_d = StAddiWb;
            StAddiWb:   state_d = StFetch;
            StJump:     state_d = StFetch;
            StFault:    state_d = StFault;
            default:    state_d = StIdle;
        endcase

        // A ready in the last allowed cycle wins over the timeout.
        if (mem_wait) begin
            if (TimeoutEn && (wait_cnt_q == WaitLast)) begin
                state_d      = StFault;
                fault_code_d = FaultTimeout;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end

        // Without trapping, the PC is already past the instruction, so it becomes a NOP.
        if (illegal) begin
            if (TRAP_ILLEGAL) begin
                state_d      = StFault;
                fault_code_d = FaultIllegal;
            end else begin
                state_d = StFetch;
            end
        end

        if ((state_d != state_q) &&
            ((state_d == StFetch) || (state_d == StMemRead) || (state_d == StMemWrite))) begin
            wait_cnt_d = '0;
        end
    end

    // Moore outputs from the current state; only fetch and branch look at inputs.
    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_write     = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_en         = 1'b0;
        bus.pc_src        = 2'b00;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_control   = AluAdd;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.illegal_instr = illegal;
        bus.fault         = (state_q == StFault);
        bus.fault_code    = fault_code_q;
        bus.state         = state_q;

        unique case (state_q)
            StFetch: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_en     = bus.mem_ready;
            end
            StDecode: bus.alu_src_b = 2'b11;
            StMemAdr: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            StMemRead: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            StMemWb: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            StMemWrite: begin
                bus.mem_req   = 1'b1;
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            StExecute: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = funct_alu;
            end
            StAluWb: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            StBranch: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = AluSub;
                bus.pc_src      = 2'b01;
                bus.pc_en       = (bus.op_code == OpBne) ? ~bus.zero_flag : bus.zero_flag;
            end
            StAddiExec: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            StAddiWb: bus.reg_write = 1'b1;
            StJump: begin
                bus.pc_src = 2'b10;
                bus.pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle MIPS control unit: a Moore FSM that sequences one instruction over 3–5 cycles through a single shared instruction/data memory.
- Replaces the single-cycle decode plus divided memory clock. Memory is accessed with a req/ready handshake at full clk, with a parametrised wait timeout and illegal-instruction handling.
- Drives the multi-cycle datapath (PC, IR, A/B, ALUOut, MDR registers).

Parameters:
- MEM_TIMEOUT, 16: max cycles waiting for mem_ready before fault; 0 disables the timeout.
- TIMEOUT_W, 5: wait counter width; must satisfy 2^TIMEOUT_W > MEM_TIMEOUT.
- TRAP_ILLEGAL, 1: 1 = illegal instruction enters FAULT; 0 = pulse illegal_instr and continue as NOP.
- ENABLE_BNE, 1: 1 = decode bne (000101); 0 = treat bne as illegal.

Ports:
- clk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- op_code  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero_flag  in  1  ALU zero
- mem_ready  in  1  memory completes access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  write qualifier for mem_req
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  IR load enable
- pc_en  out  1  PC load enable
- pc_src  out  2  PC mux select: 00 ALU, 01 ALUOut, 10 jump target
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- reg_write  out  1  register file write enable
- reg_dst  out  1  destination select: 1 = rd, 0 = rt
- mem_to_reg  out  1  write-back select: 1 = MDR, 0 = ALUOut
- illegal_instr  out  1  one-cycle pulse on illegal decode
- fault  out  1  sticky; high while in FAULT
- fault_code  out  2  00 none, 01 memory timeout, 10 illegal instruction
- state  out  4  current state, debug

Behaviour:
- States: IDLE=0, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP, FAULT=13.
- Reset: state=IDLE, wait_cnt=0, fault_code=00. All outputs 0; alu_control=010. IDLE→FETCH unconditionally on the next clk.
- Reset mid-instruction: aborts immediately, outputs 0 asynchronously.
- Outputs are decoded from state only, except where gated by mem_ready or zero_flag.
- Any signal not listed for a state is 0; alu_control defaults to 010.
- FETCH: mem_req=1, iord=0, src_a=0, src_b=01, add, pc_src=00. ir_write=pc_en=mem_ready. Stays in FETCH until mem_ready, then → DECODE.
- DECODE: src_a=0, src_b=11, add. Next state by op_code:
  - 100011 (lw) / 101011 (sw) → MEMADR
  - 000000 (R-type) → EXECUTE
  - 000100 (beq), 000101 (bne, if ENABLE_BNE) → BRANCH
  - 001000 (addi) → ADDIEXEC
  - 000010 (j) → JUMP
  - anything else: illegal
- MEMADR: src_a=1, src_b=10, add. → MEMREAD for lw, → MEMWRITE for sw.
- MEMREAD: mem_req=1, iord=1. Waits for mem_ready, then → MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. → FETCH.
- MEMWRITE: mem_req=1, mem_write=1, iord=1. Waits for mem_ready, then → FETCH.
- EXECUTE: src_a=1, src_b=00. alu_control from funct:
  - 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111
  - other funct: illegal
  - legal funct → ALUWB
- ALUWB: reg_write=1, reg_dst=1. → FETCH.
- BRANCH: src_a=1, src_b=00, sub, pc_src=01. pc_en = zero_flag for beq, ~zero_flag for bne. → FETCH.
- ADDIEXEC: src_a=1, src_b=10, add. → ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0. → FETCH.
- JUMP: pc_src=10, pc_en=1. → FETCH.
- Illegal instruction (detected in DECODE, or in EXECUTE for bad funct):
  - illegal_instr=1 for that cycle.
  - TRAP_ILLEGAL=1: → FAULT, fault_code=10.
  - TRAP_ILLEGAL=0: → FETCH. PC is already advanced, so the instruction acts as a NOP.
- Wait counter:
  - Cleared on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments each cycle in a memory state with mem_ready=0.
  - If MEM_TIMEOUT≠0 and wait_cnt==MEM_TIMEOUT-1 with mem_ready=0 → FAULT, fault_code=01.
  - mem_ready in that same cycle wins: no fault.
- mem_ready is ignored outside memory states.
- FAULT: all control outputs 0, fault=1. Only exit is arst_n.
- Zero-wait memory (mem_ready tied 1) gives CPI: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3.

Test Plan:
- Reset, mem_ready=1, add R-type (op 000000, funct 100000) → state IDLE, FETCH, DECODE, EXECUTE(alu_control=010), ALUWB(reg_write=1, reg_dst=1), FETCH; ir_write=pc_en=1 only in the FETCH cycle.
- lw with mem_ready low 3 cycles in each of FETCH and MEMREAD → mem_req held; ir_write/pc_en single pulse when ready; total 11 cycles FETCH to next FETCH; MEMWB has mem_to_reg=1.
- beq with zero_flag=0 → pc_en=0 in BRANCH; bne with zero_flag=0 → pc_en=1, pc_src=01; ENABLE_BNE=0 → bne yields illegal_instr pulse.
- MEM_TIMEOUT=16, mem_ready held 0 in FETCH → FAULT after exactly 16 FETCH cycles, fault=1, fault_code=01; ready asserted on the 16th cycle → no fault.
- op 111111 with TRAP_ILLEGAL=1 → FAULT, fault_code=10; with TRAP_ILLEGAL=0 → one illegal_instr pulse, next state FETCH.
- arst_n low during MEMWRITE with mem_req=1 → mem_req/mem_write drop immediately, state=0; after release, FETCH next cycle.
